// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front-end ahead of the memory controller's
// instruction port. It issues sequential word fetches, each followed by a
// mandatory one-cycle enable gap. Returned words are queued with their PC
// and handed to decode over a valid/ready interface. Redirects flush the
// queue and restart fetching at a new PC. A response that is already in
// flight when a redirect arrives is squashed.
//
// Optional feature macro: IFETCH_ALIGN_CHECK_EN. When defined, a misaligned
// redirect queues a single fault marker and then halts fetching. When it is
// undefined, the low two bits of redirect_pc are forced to zero.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   redirect_valid, redirect_pc   one-cycle restart request with target PC
//   instr_enable, instr_addr      fetch request to the memory controller
//   instr_valid, instr_result     one-cycle response strobe and data word
//   out_valid, out_ready          decode handshake for the queue head
//   out_instr, out_pc, out_fault  queue head contents
module instr_fetch #(
    parameter logic [24:0] RESET_PC = 25'h0,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [24:0] redirect_pc,
    output logic        instr_enable,
    output logic [24:0] instr_addr,
    input  logic        instr_valid,
    input  logic [31:0] instr_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [24:0] out_pc,
    output logic        out_fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef IFETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_REQ, S_GAP, S_WAIT, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_GAP, S_WAIT} state_t;
`endif

    state_t        state;
    logic [24:0]   fetch_pc;
    logic          squash;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   mem_instr [DEPTH];
    logic [24:0]   mem_pc    [DEPTH];

    logic          push;
    logic          pop;
    logic [31:0]   push_instr;
    logic [24:0]   redir_pc;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic          mem_fault [DEPTH];
    logic          pend_fault;   // misaligned redirect still waiting to queue its marker
    logic          push_fault;
    logic          misalign;
    assign redir_pc  = redirect_pc;
    assign misalign  = |redirect_pc[1:0];
    assign out_fault = mem_fault[rd_ptr];
`else
    assign redir_pc  = redirect_pc & ~25'h3;
    assign out_fault = 1'b0;
`endif

    // All outputs come straight from state registers.
    assign instr_enable = (state == S_REQ);
    assign out_valid    = (count != '0);
    assign out_instr    = mem_instr[rd_ptr];
    assign out_pc       = mem_pc[rd_ptr];
    assign pop          = out_valid && out_ready;

    always_comb begin
        push       = 1'b0;
        push_instr = instr_result;
`ifdef IFETCH_ALIGN_CHECK_EN
        push_fault = 1'b0;
`endif
        if (!redirect_valid) begin
            if (state == S_REQ && instr_valid && !squash)
                push = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
            // GAP is reached only after any squashed response has returned.
            if (state == S_GAP && pend_fault) begin
                push       = 1'b1;
                push_instr = '0;
                push_fault = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_GAP;
            fetch_pc   <= RESET_PC;
            instr_addr <= RESET_PC;
            squash     <= 1'b0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
                mem_fault[i] <= 1'b0;
`endif
            end
`ifdef IFETCH_ALIGN_CHECK_EN
            pend_fault <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // A redirect wins over any push or pop in the same cycle.
            fetch_pc <= redir_pc;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
            pend_fault <= misalign;
`endif
            // An outstanding request cannot be withdrawn, so keep the handshake
            // open on the old address and throw its response away.
            if (state == S_REQ && !instr_valid) begin
                squash <= 1'b1;
            end else begin
                squash <= 1'b0;
                state  <= S_GAP;
            end
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= push_instr;
                mem_pc[wr_ptr]    <= fetch_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
                mem_fault[wr_ptr] <= push_fault;
`endif
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (!push && pop)
                count <= count - CW'(1);

            case (state)
                S_REQ: begin
                    if (instr_valid) begin
                        if (!squash)
                            fetch_pc <= fetch_pc + 25'd4;
                        squash <= 1'b0;
                        state  <= S_GAP;
                    end
                end
                S_GAP: begin
`ifdef IFETCH_ALIGN_CHECK_EN
                    if (pend_fault) begin
                        pend_fault <= 1'b0;
                        state      <= S_FAULT;
                    end else
`endif
                    if (count < FULL) begin
                        state      <= S_REQ;
                        instr_addr <= fetch_pc;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (count < FULL) begin
                        state      <= S_REQ;
                        instr_addr <= fetch_pc;
                    end
                end
                default: ;   // FAULT holds until a redirect
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch. It includes a memory
// controller model with a 3-cycle response latency, plus monitors that log
// the requests issued and the words accepted by decode.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [24:0] redirect_pc;
    logic        instr_enable;
    logic [24:0] instr_addr;
    logic        instr_valid;
    logic [31:0] instr_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [24:0] out_pc;
    logic        out_fault;

    instr_fetch #(.RESET_PC(25'h100), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_enable(instr_enable), .instr_addr(instr_addr),
        .instr_valid(instr_valid), .instr_result(instr_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [24:0] pc;
        logic [31:0] instr;
        logic        fault;
    } out_t;

    out_t        out_log [$];
    logic [24:0] req_log [$];
    int          req_cyc [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        prev_en = 1'b0;

    function automatic logic [31:0] word(input logic [24:0] a);
        return {7'h5A, a};
    endfunction

    // Memory model: the request is captured in cycle k and the response is
    // strobed in cycle k+3.
    logic        busy = 1'b0;
    int          lat = 0;
    logic [24:0] maddr = '0;
    initial begin instr_valid = 1'b0; instr_result = '0; end
    always @(negedge clk) begin
        if (rst) begin
            instr_valid = 1'b0; busy = 1'b0; lat = 0;
        end else if (instr_valid) begin
            instr_valid = 1'b0; busy = 1'b0;
        end else if (busy) begin
            lat++;
            if (lat == 3) begin instr_valid = 1'b1; instr_result = word(maddr); end
        end else if (instr_enable) begin
            busy = 1'b1; lat = 0; maddr = instr_addr;
        end
    end

    // Monitor: samples late in each cycle, after the stimulus has settled.
    always begin
        @(negedge clk); #3;
        cyc++;
        if (rst) prev_en = 1'b0;
        else begin
            if (instr_enable && !prev_en) begin
                req_log.push_back(instr_addr);
                req_cyc.push_back(cyc);
            end
            prev_en = instr_enable;
            if (out_valid && out_ready) out_log.push_back({out_pc, out_instr, out_fault});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        out_log.delete(); req_log.delete(); req_cyc.delete();
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1; redirect_valid = 1'b0; out_ready = rdy;
        tick(3);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_req(input int n);
        int b = 0;
        while (req_log.size() < n && b < 200) begin tick(1); b++; end
        chk("req_timeout", 32'(req_log.size() >= n), 32'd1);
    endtask

    task automatic wait_out(input int n);
        int b = 0;
        while (out_log.size() < n && b < 200) begin tick(1); b++; end
        chk("out_timeout", 32'(out_log.size() >= n), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int b;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        tick(3);
        chk("rst_en",    32'(instr_enable), 32'd0);
        chk("rst_addr",  32'(instr_addr),   32'h100);
        chk("rst_ov",    32'(out_valid),    32'd0);
        chk("rst_instr", out_instr,         32'd0);
        chk("rst_pc",    32'(out_pc),       32'd0);
        chk("rst_fault", 32'(out_fault),    32'd0);

        // Sequential fetch with out_ready=1.
        rst = 1'b0; clear_logs();
        tick(1);
        chk("first_en",   32'(instr_enable), 32'd1);
        chk("first_addr", 32'(instr_addr),   32'h100);
        tick(4);
        chk("resp_ov",    32'(out_valid),    32'd1);
        chk("resp_pc",    32'(out_pc),       32'h100);
        chk("resp_instr", out_instr,         word(25'h100));
        chk("gap_en",     32'(instr_enable), 32'd0);
        tick(1);
        chk("second_en",   32'(instr_enable), 32'd1);
        chk("second_addr", 32'(instr_addr),   32'h104);
        chk("popped_ov",   32'(out_valid),    32'd0);
        wait_out(3);
        chk("seq_req0", 32'(req_log[0]), 32'h100);
        chk("seq_req1", 32'(req_log[1]), 32'h104);
        chk("seq_req2", 32'(req_log[2]), 32'h108);
        chk("seq_period", 32'(req_cyc[1] - req_cyc[0]), 32'd5);
        chk("seq_out0", 32'(out_log[0].pc), 32'h100);
        chk("seq_out1", 32'(out_log[1].pc), 32'h104);
        chk("seq_out2", 32'(out_log[2].pc), 32'h108);
        chk("seq_w2",   out_log[2].instr,   word(25'h108));

        // Backpressure: with DEPTH=2, only two requests are issued.
        do_reset(1'b0);
        tick(40);
        chk("bp_reqs", 32'(req_log.size()), 32'd2);
        chk("bp_en",   32'(instr_enable),   32'd0);
        chk("bp_ov",   32'(out_valid),      32'd1);
        chk("bp_pc",   32'(out_pc),         32'h100);
        out_ready = 1'b1;
        wait_req(3);
        chk("bp_req2", 32'(req_log[2]), 32'h108);
        wait_out(3);
        chk("bp_out0", 32'(out_log[0].pc), 32'h100);
        chk("bp_out2", 32'(out_log[2].pc), 32'h108);

        // Redirect while the request to 0x104 is pending.
        do_reset(1'b0);
        b = 0;
        while (!(instr_enable && instr_addr == 25'h104) && b < 200) begin tick(1); b++; end
        chk("sq_wait", 32'(b < 200), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 25'h400;
        tick(1);
        redirect_valid = 1'b0;
        chk("sq_ov",   32'(out_valid),    32'd0);
        chk("sq_en",   32'(instr_enable), 32'd1);
        chk("sq_addr", 32'(instr_addr),   32'h104);
        clear_logs();
        out_ready = 1'b1;
        wait_req(1);
        chk("sq_req", 32'(req_log[0]), 32'h400);
        wait_out(1);
        chk("sq_out_pc", 32'(out_log[0].pc), 32'h400);
        chk("sq_out_w",  out_log[0].instr,   word(25'h400));

        // Redirect coinciding with the response and a pop.
        do_reset(1'b0);
        b = 0;
        while (!(instr_valid && instr_addr == 25'h104) && b < 200) begin tick(1); b++; end
        chk("co_wait", 32'(b < 200), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 25'h500; out_ready = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        chk("co_ov",   32'(out_valid),      32'd0);
        chk("co_en",   32'(instr_enable),   32'd0);
        chk("co_pops", 32'(out_log.size()), 32'd1);
        chk("co_pop0", 32'(out_log[0].pc),  32'h100);
        wait_req(3);
        chk("co_req", 32'(req_log[2]), 32'h500);
        wait_out(2);
        chk("co_out", 32'(out_log[1].pc), 32'h500);

        // fetch_pc wraps modulo 2^25.
        do_reset(1'b1);
        redirect_valid = 1'b1; redirect_pc = 25'h1FFFFFC;
        tick(1);
        redirect_valid = 1'b0;
        wait_req(2);
        chk("wrap_req0", 32'(req_log[0]), 32'h1FFFFFC);
        chk("wrap_req1", 32'(req_log[1]), 32'h0);
        wait_out(2);
        chk("wrap_out1", 32'(out_log[1].pc), 32'h0);

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned redirect queues a fault marker and halts fetching.
        do_reset(1'b1);
        b = 0;
        while (!(instr_enable && instr_addr == 25'h104) && b < 200) begin tick(1); b++; end
        chk("flt_wait", 32'(b < 200), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 25'h202;
        tick(1);
        redirect_valid = 1'b0;
        clear_logs();
        wait_out(1);
        chk("flt_pc",    32'(out_log[0].pc),    32'h202);
        chk("flt_bit",   32'(out_log[0].fault), 32'd1);
        chk("flt_instr", out_log[0].instr,      32'd0);
        tick(30);
        chk("flt_noreq", 32'(req_log.size()), 32'd0);
        chk("flt_en",    32'(instr_enable),   32'd0);
        redirect_valid = 1'b1; redirect_pc = 25'h300;
        tick(1);
        redirect_valid = 1'b0;
        wait_req(1);
        chk("flt_resume", 32'(req_log[0]), 32'h300);
        wait_out(2);
        chk("flt_out1_pc", 32'(out_log[1].pc),    32'h300);
        chk("flt_out1_f",  32'(out_log[1].fault), 32'd0);
`else
        // Misaligned redirect target is forced to word alignment.
        do_reset(1'b1);
        redirect_valid = 1'b1; redirect_pc = 25'h202;
        tick(1);
        redirect_valid = 1'b0;
        wait_req(2);
        chk("align_req0", 32'(req_log[0]), 32'h200);
        chk("align_req1", 32'(req_log[1]), 32'h204);
        wait_out(1);
        chk("align_fault", 32'(out_log[0].fault), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front-end sitting directly upstream of the memory controller's instruction port. Generates sequential word fetch addresses, drives the `instr_enable`/`instr_valid` request handshake, buffers returned words with their PCs in a small FIFO and presents them to decode with valid/ready flow control. Handles control-flow redirects, including squashing a response already in flight.

## Interface
- `RESET_PC`, 25'h0, byte address of the first fetch after reset
- `DEPTH`, 2, FIFO entries (power of two, ≥2)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `redirect_valid`  in  1  one-cycle pulse: discard all fetched/pending words, restart at `redirect_pc`
- `redirect_pc`  in  25  new byte fetch address
- `instr_enable`  out  1  request to memory controller
- `instr_addr`  out  25  request byte address, stable while `instr_enable`=1
- `instr_valid`  in  1  response strobe, one cycle
- `instr_result`  in  32  response word, valid with `instr_valid`
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  decode accepts head this cycle
- `out_instr`  out  32  head instruction word
- `out_pc`  out  25  head PC
- `out_fault`  out  1  head is a misaligned-fetch fault marker (see Configuration)

## Operation
- Registers: `fetch_pc` (25b), FIFO of {instr, pc, fault}, `count` (0..DEPTH), `squash` flag, FSM.
- FSM states: REQ (`instr_enable`=1), GAP (`instr_enable`=0, one cycle), WAIT (`instr_enable`=0, FIFO slot unavailable), FAULT (halted).
- Issue rule: REQ is entered only when `count` < DEPTH; the in-flight request reserves that slot.
- REQ: hold `instr_enable`=1, `instr_addr`=`fetch_pc`. On `instr_valid`: if `squash`=0, push {`instr_result`, `fetch_pc`, 0}, `fetch_pc` += 4; always clear `squash`; go to GAP.
- GAP: mandatory one-cycle deassert after every response (the controller re-arms on enable && !valid). Then REQ if a slot is free, else WAIT.
- WAIT: go to REQ in the cycle after `count` < DEPTH.
- Pop: `out_valid` && `out_ready` removes head. Simultaneous push and pop leaves `count` unchanged.
- `fetch_pc` arithmetic is modulo 2^25; 25'h1FFFFFC + 4 wraps to 0.
- Redirect (any state): FIFO flushed (`count`=0, `out_valid`=0 next cycle), `fetch_pc`=`redirect_pc`. If in REQ without `instr_valid` this cycle: stay in REQ, keep the old `instr_addr`, set `squash`=1, and on the response go to GAP and fetch `redirect_pc` next. If `instr_valid` arrives in the same cycle: drop the response, go to GAP.
- Redirect beats a pop in the same cycle; the popped word is still consumed by decode.
- A second redirect while `squash`=1 only updates `fetch_pc`.

## Timing
- Reset values: `instr_enable`=0, `instr_addr`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_fault`=0, `count`=0, `squash`=0, state GAP, `fetch_pc`=RESET_PC.
- `rst` asserted mid-request abandons it without waiting for `instr_valid`; the controller resets alongside.
- First `instr_enable` is high in the 2nd cycle after `rst` falls.
- Response to output: word captured on the edge where `instr_valid`=1; `out_valid`=1 the next cycle.
- Peak throughput: one word per (controller latency + 2) cycles.
- All outputs are registered; no combinational path from `out_ready` or `instr_valid` to `instr_enable`.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]`≠0 flushes as normal.
  - Pushes one entry {0, `redirect_pc`, fault=1} once no squashed request is pending, then enters FAULT and issues no requests.
  - Only a subsequent redirect leaves FAULT.
- Undefined:
  - `redirect_pc[1:0]` is forced to 0.
  - `out_fault` is tied 0 and the FAULT state is absent.

## Test plan
- Reset, RESET_PC=0x100, memory answers with a 3-cycle latency, `out_ready`=1 → requests 0x100, 0x104, 0x108 with a one-cycle `instr_enable` gap between them; output PCs appear in order with the matching words.
- `out_ready`=0, DEPTH=2 → exactly 2 requests, then `instr_enable` stays 0; raise `out_ready` → the next request is to 0x108.
- Redirect to 0x400 while a request to 0x104 is pending → 0x104 response discarded, `out_valid` low, next request to 0x400, first output pc=0x400.
- Redirect in the same cycle as `instr_valid` plus a pop → response dropped, FIFO empty next cycle, next fetch from the redirect target.
- `fetch_pc`=0x1FFFFFC → next request is to address 0.
- With `IFETCH_ALIGN_CHECK_EN`: redirect to 0x202 → one output with `out_fault`=1, pc=0x202, then no requests; redirect to 0x300 resumes fetching.
